// File: rtl/rx_frame_checker.sv
// Receive-side UART frame checker: parity (five modes) and start/stop framing
// checks feeding a first-word-fall-through result FIFO, with saturating error counters.
module rx_frame_checker #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                            i_Pclk,
    input  logic                            i_Rstn,
    input  logic [2:0]                      i_Parity,
    input  logic [DATA_W+2:0]               i_Data,
    input  logic                            i_Valid,
    output logic                            o_Ready,
    output logic [DATA_W-1:0]               o_Data,
    output logic                            o_ParityOK,
    output logic                            o_FrameOK,
    output logic                            o_Valid,
    input  logic                            i_Ready,
    input  logic                            i_ClrCnt,
    output logic [CNT_W-1:0]                o_ParErrCnt,
    output logic [CNT_W-1:0]                o_FrmErrCnt,
    output logic [$clog2(FIFO_DEPTH):0]     o_Level
);

    localparam int FRAME_W = DATA_W + 3;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 2;

    localparam logic [2:0] MODE_NONE  = 3'b000;
    localparam logic [2:0] MODE_EVEN  = 3'b001;
    localparam logic [2:0] MODE_ODD   = 3'b010;
    localparam logic [2:0] MODE_MARK  = 3'b011;
    localparam logic [2:0] MODE_SPACE = 3'b100;

    localparam logic [LVL_W:0] DEPTH_C = (LVL_W+1)'(FIFO_DEPTH);

    // Parity check over payload plus parity bit; unknown modes behave as "none".
    function automatic logic parity_ok(input logic [FRAME_W-1:0] frame, input logic [2:0] mode);
        logic ones_odd;
        ones_odd = ^frame[DATA_W+1:1];
        case (mode)
            MODE_NONE:  parity_ok = 1'b1;
            MODE_EVEN:  parity_ok = ~ones_odd;
            MODE_ODD:   parity_ok = ones_odd;
            MODE_MARK:  parity_ok = frame[1];
            MODE_SPACE: parity_ok = ~frame[1];
            default:    parity_ok = 1'b1;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}}) begin
            sat_inc = cnt;
        end else begin
            sat_inc = cnt + CNT_W'(1);
        end
    endfunction

    logic                s1_valid_r;
    logic [DATA_W-1:0]   s1_data_r;
    logic                s1_pok_r;
    logic                s1_fok_r;
    logic [ENTRY_W-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_next_s;
    logic [LVL_W-1:0]    level_after_pop_s;
    logic [LVL_W-1:0]    level_next_s;
    logic [LVL_W:0]      occupancy_s;
    logic [ENTRY_W-1:0]  head_next_s;
    logic                valid_next_s;
    logic                accept_s;
    logic                push_s;
    logic                pop_s;
    logic                pok_s;
    logic                fok_s;

    // Ready counts the frame still sitting in the check stage so the FIFO never overflows.
    always_comb begin
        occupancy_s = (LVL_W+1)'(o_Level) + (LVL_W+1)'(s1_valid_r);
        if (!i_Rstn) begin
            o_Ready = 1'b0;
        end else begin
            o_Ready = (occupancy_s < DEPTH_C);
        end
    end

    assign accept_s = i_Valid & o_Ready;
    assign push_s   = s1_valid_r;
    assign pop_s    = o_Valid & i_Ready;
    assign pok_s    = parity_ok(i_Data, i_Parity);
    assign fok_s    = ~i_Data[FRAME_W-1] & i_Data[0];

    // Next head: bypass the incoming entry when it lands in an otherwise empty FIFO.
    always_comb begin
        rd_ptr_next_s     = rd_ptr_r + PTR_W'(pop_s);
        level_after_pop_s = o_Level - LVL_W'(pop_s);
        level_next_s      = level_after_pop_s + LVL_W'(push_s);
        valid_next_s      = (level_next_s != {LVL_W{1'b0}});
        head_next_s       = {o_Data, o_ParityOK, o_FrameOK};
        if (push_s && (level_after_pop_s == {LVL_W{1'b0}})) begin
            head_next_s = {s1_data_r, s1_pok_r, s1_fok_r};
        end else if (valid_next_s) begin
            head_next_s = mem_r[rd_ptr_next_s];
        end else begin
            head_next_s = {o_Data, o_ParityOK, o_FrameOK};
        end
    end

    // Check stage: captures the frame and its check results on accept.
    always_ff @(posedge i_Pclk) begin
        if (!i_Rstn) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DATA_W{1'b0}};
            s1_pok_r   <= 1'b0;
            s1_fok_r   <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_data_r <= i_Data[DATA_W+1:2];
                s1_pok_r  <= pok_s;
                s1_fok_r  <= fok_s;
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge i_Pclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {s1_data_r, s1_pok_r, s1_fok_r};
        end
    end

    // FIFO pointers, occupancy and registered head outputs.
    always_ff @(posedge i_Pclk) begin
        if (!i_Rstn) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            o_Level    <= {LVL_W{1'b0}};
            o_Valid    <= 1'b0;
            o_Data     <= {DATA_W{1'b0}};
            o_ParityOK <= 1'b0;
            o_FrameOK  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r                          <= rd_ptr_next_s;
            o_Level                           <= level_next_s;
            o_Valid                           <= valid_next_s;
            {o_Data, o_ParityOK, o_FrameOK}   <= head_next_s;
        end
    end

    // Error counters: clear wins over a same-edge increment.
    always_ff @(posedge i_Pclk) begin
        if (!i_Rstn) begin
            o_ParErrCnt <= {CNT_W{1'b0}};
            o_FrmErrCnt <= {CNT_W{1'b0}};
        end else if (i_ClrCnt) begin
            o_ParErrCnt <= {CNT_W{1'b0}};
            o_FrmErrCnt <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            if (!pok_s) begin
                o_ParErrCnt <= sat_inc(o_ParErrCnt);
            end
            if (!fok_s) begin
                o_FrmErrCnt <= sat_inc(o_FrmErrCnt);
            end
        end
    end

endmodule
